// File: rtl/sprite_row_fetch.sv
// Sprite row fetcher: reads one 64-pixel 4-bpp sprite row from a fixed-latency ROM
// into a back line buffer, then swaps it to the displayed front buffer on a line strobe.
module sprite_row_fetch #(
  parameter int ROM_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic [2:0]  sprite_sel_i,
  input  logic [5:0]  row_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        line_ready_o,
  input  logic        swap_i,
  output logic [2:0]  rom_sprite_sel_o,
  output logic [9:0]  rom_word_addr_o,
  input  logic [15:0] rom_data_i,
  input  logic [5:0]  pix_x_i,
  output logic [3:0]  pix_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_k;
  logic [9:0]  r_addr;
  logic [2:0]  r_sel;
  logic        r_busy;
  logic        r_done;
  logic        r_line_ready;
  logic        r_front_valid;
  logic        r_front_sel;
  logic [3:0]  r_pix;

  // Each stage carries {valid, word index}; the oldest stage sits in the top 5 bits.
  logic [5*ROM_LAT-1:0] r_pipe;
  logic [5*ROM_LAT+4:0] w_pipe_next;

  // Line buffers stored as 16 words of 4 pixels each; r_front_sel picks the displayed one.
  logic [15:0] r_buf0 [16];
  logic [15:0] r_buf1 [16];

  logic        w_accept;
  logic        w_wr_valid;
  logic [3:0]  w_wr_idx;
  logic        w_last_write;
  logic [15:0] w_front_word;
  logic [3:0]  w_front_pix;

  assign ready_o          = (r_state == IDLE) && !r_line_ready;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign line_ready_o     = r_line_ready;
  assign rom_sprite_sel_o = r_sel;
  assign rom_word_addr_o  = r_addr;
  assign pix_o            = r_pix;

  assign w_accept     = ready_o && req_i;
  assign w_pipe_next  = {r_pipe, (r_state == ISSUE), r_k};
  assign w_wr_valid   = r_pipe[5*ROM_LAT-1];
  assign w_wr_idx     = r_pipe[5*ROM_LAT-2 -: 4];
  assign w_last_write = w_wr_valid && (w_wr_idx == 4'hF);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= 4'd0;
      r_addr  <= 10'd0;
      r_sel   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= ISSUE;
            r_k     <= 4'd0;
            r_addr  <= {row_i, 4'h0};
            r_sel   <= sprite_sel_i;
            r_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (r_k == 4'hF) begin
            r_state <= DRAIN;
          end else begin
            r_k    <= r_k + 4'd1;
            r_addr <= r_addr + 10'd1;
          end
        end
        DRAIN: begin
          if (w_last_write) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= w_pipe_next[5*ROM_LAT-1:0];
    end
  end

  // No swap can coincide with the row completing: line_ready is low throughout a fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_line_ready  <= 1'b0;
      r_front_valid <= 1'b0;
      r_front_sel   <= 1'b0;
    end else if (swap_i && r_line_ready) begin
      r_line_ready  <= 1'b0;
      r_front_valid <= 1'b1;
      r_front_sel   <= !r_front_sel;
    end else if ((r_state == DRAIN) && w_last_write) begin
      r_line_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_valid) begin
      if (r_front_sel) begin
        r_buf0[w_wr_idx] <= rom_data_i;
      end else begin
        r_buf1[w_wr_idx] <= rom_data_i;
      end
    end
  end

  always_comb begin
    w_front_word = r_front_sel ? r_buf1[pix_x_i[5:2]] : r_buf0[pix_x_i[5:2]];
    w_front_pix  = 4'd0;
    case (pix_x_i[1:0])
      2'd0:    w_front_pix = w_front_word[15:12];
      2'd1:    w_front_pix = w_front_word[11:8];
      2'd2:    w_front_pix = w_front_word[7:4];
      default: w_front_pix = w_front_word[3:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix <= 4'd0;
    end else begin
      r_pix <= r_front_valid ? w_front_pix : 4'd0;
    end
  end

endmodule

// File: tb/tb_sprite_row_fetch.sv
// Directed bench for sprite_row_fetch: one instance at ROM_LAT=3 and one at ROM_LAT=1,
// both driven with identical stimulus and each backed by its own latency-matched ROM model.
module tb_sprite_row_fetch;

  logic clk;
  logic reset;
  logic req;
  logic [2:0] spriteSel;
  logic [5:0] row;
  logic swap;
  logic [5:0] pixX;

  logic readyA, busyA, doneA, lrA;
  logic [2:0] romSelA;
  logic [9:0] romAddrA;
  logic [15:0] romDataA;
  logic [3:0] pixA;

  logic readyB, busyB, doneB, lrB;
  logic [2:0] romSelB;
  logic [9:0] romAddrB;
  logic [15:0] romDataB;
  logic [3:0] pixB;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sprite_row_fetch #(.ROM_LAT(3)) dutA (
    .clk(clk), .reset(reset), .req_i(req), .sprite_sel_i(spriteSel), .row_i(row),
    .ready_o(readyA), .busy_o(busyA), .done_o(doneA), .line_ready_o(lrA), .swap_i(swap),
    .rom_sprite_sel_o(romSelA), .rom_word_addr_o(romAddrA), .rom_data_i(romDataA),
    .pix_x_i(pixX), .pix_o(pixA)
  );

  sprite_row_fetch #(.ROM_LAT(1)) dutB (
    .clk(clk), .reset(reset), .req_i(req), .sprite_sel_i(spriteSel), .row_i(row),
    .ready_o(readyB), .busy_o(busyB), .done_o(doneB), .line_ready_o(lrB), .swap_i(swap),
    .rom_sprite_sel_o(romSelB), .rom_word_addr_o(romAddrB), .rom_data_i(romDataB),
    .pix_x_i(pixX), .pix_o(pixB)
  );

  function automatic logic [15:0] romWord(input logic [2:0] s, input logic [9:0] a);
    if (s == 3'd2 && a == 10'h050) return 16'h1234;
    return (16'(a) * 16'd37) ^ {s, 13'h0A5B};
  endfunction

  function automatic logic [3:0] pixelOf(input logic [2:0] s, input logic [5:0] r, input logic [5:0] x);
    logic [15:0] w;
    w = romWord(s, {r, x[5:2]});
    case (x[1:0])
      2'd0:    return w[15:12];
      2'd1:    return w[11:8];
      2'd2:    return w[7:4];
      default: return w[3:0];
    endcase
  endfunction

  // ROM models: data for an address presented in cycle c appears in cycle c+LAT.
  logic [15:0] romPipeA [3];
  logic [15:0] romPipeB;
  always @(posedge clk) begin
    romPipeA[0] <= romWord(romSelA, romAddrA);
    romPipeA[1] <= romPipeA[0];
    romPipeA[2] <= romPipeA[1];
    romPipeB    <= romWord(romSelB, romAddrB);
  end
  assign romDataA = romPipeA[2];
  assign romDataB = romPipeB;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFetch(input string name, input int lat, input int cyc, input int swapCycle,
                            input logic [9:0] base, input logic [2:0] s,
                            input logic obsBusy, input logic obsDone, input logic obsLr,
                            input logic obsReady, input logic [9:0] obsAddr, input logic [2:0] obsSel);
    logic expBusy, expDone, expLr, expReady;
    logic [9:0] expAddr;
    expBusy  = (cyc >= 1) && (cyc <= 16 + lat);
    expDone  = (cyc == 17 + lat);
    expLr    = (cyc >= 17 + lat) && !((swapCycle >= 17 + lat) && (cyc > swapCycle));
    expReady = (cyc >= 18 + lat) && !expLr;
    expAddr  = (cyc <= 16) ? base + 10'(cyc - 1) : base + 10'd15;
    checkOutput($sformatf("%s_busy_c%0d", name, cyc), 32'(obsBusy), 32'(expBusy));
    checkOutput($sformatf("%s_done_c%0d", name, cyc), 32'(obsDone), 32'(expDone));
    checkOutput($sformatf("%s_lineready_c%0d", name, cyc), 32'(obsLr), 32'(expLr));
    checkOutput($sformatf("%s_ready_c%0d", name, cyc), 32'(obsReady), 32'(expReady));
    checkOutput($sformatf("%s_addr_c%0d", name, cyc), 32'(obsAddr), 32'(expAddr));
    checkOutput($sformatf("%s_romsel_c%0d", name, cyc), 32'(obsSel), 32'(s));
  endtask

  // Entered in cycle 0 with both instances idle; a stray request at cycle 5 must be ignored.
  task automatic applyStimulus(input logic [2:0] s, input logic [5:0] r, input int swapCycle);
    logic [9:0] base;
    base = {r, 4'h0};
    checkOutput("readyA_c0", 32'(readyA), 32'd1);
    checkOutput("readyB_c0", 32'(readyB), 32'd1);
    req = 1'b1;
    spriteSel = s;
    row = r;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      tick();
      checkFetch("A", 3, cyc, swapCycle, base, s, busyA, doneA, lrA, readyA, romAddrA, romSelA);
      checkFetch("B", 1, cyc, swapCycle, base, s, busyB, doneB, lrB, readyB, romAddrB, romSelB);
      req = 1'b0;
      if (cyc == 5) begin
        req = 1'b1;
        spriteSel = 3'd3;
        row = 6'd9;
      end
      swap = (cyc == swapCycle);
    end
    req = 1'b0;
    swap = 1'b0;
  endtask

  task automatic checkPixels(input logic [2:0] s, input logic [5:0] r);
    for (int x = 0; x < 64; x++) begin
      pixX = 6'(x);
      tick();
      checkOutput($sformatf("pixA_s%0d_r%0d_x%0d", s, r, x), 32'(pixA), 32'(pixelOf(s, r, 6'(x))));
      checkOutput($sformatf("pixB_s%0d_r%0d_x%0d", s, r, x), 32'(pixB), 32'(pixelOf(s, r, 6'(x))));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    req = 1'b0;
    spriteSel = 3'd0;
    row = 6'd0;
    swap = 1'b0;
    pixX = 6'd0;

    repeat (3) tick();
    checkOutput("rst_busyA", 32'(busyA), 32'd0);
    checkOutput("rst_doneA", 32'(doneA), 32'd0);
    checkOutput("rst_lrA", 32'(lrA), 32'd0);
    checkOutput("rst_pixA", 32'(pixA), 32'd0);
    checkOutput("rst_addrA", 32'(romAddrA), 32'd0);
    checkOutput("rst_selA", 32'(romSelA), 32'd0);
    checkOutput("rst_busyB", 32'(busyB), 32'd0);
    checkOutput("rst_lrB", 32'(lrB), 32'd0);
    checkOutput("rst_pixB", 32'(pixB), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("postrst_readyA", 32'(readyA), 32'd1);

    swap = 1'b1;
    tick();
    swap = 1'b0;
    checkOutput("earlyswap_lrA", 32'(lrA), 32'd0);
    tick();
    checkOutput("earlyswap_pixA", 32'(pixA), 32'd0);
    checkOutput("earlyswap_pixB", 32'(pixB), 32'd0);
    pixX = 6'd5;
    tick();
    checkOutput("earlyswap_pixA_x5", 32'(pixA), 32'd0);

    applyStimulus(3'd2, 6'd5, 0);

    checkOutput("bp_readyA", 32'(readyA), 32'd0);
    req = 1'b1;
    spriteSel = 3'd4;
    row = 6'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("bp_busyA", 32'(busyA), 32'd0);
      checkOutput("bp_addrA", 32'(romAddrA), 32'h05F);
      checkOutput("bp_busyB", 32'(busyB), 32'd0);
      checkOutput("bp_addrB", 32'(romAddrB), 32'h05F);
    end
    req = 1'b0;
    swap = 1'b1;
    tick();
    swap = 1'b0;
    checkOutput("swap_lrA", 32'(lrA), 32'd0);
    checkOutput("swap_lrB", 32'(lrB), 32'd0);
    checkOutput("swap_readyA", 32'(readyA), 32'd1);
    checkPixels(3'd2, 6'd5);

    applyStimulus(3'd7, 6'd63, 20);
    checkPixels(3'd7, 6'd63);

    checkOutput("midrst_readyA_c0", 32'(readyA), 32'd1);
    req = 1'b1;
    spriteSel = 3'd1;
    row = 6'd10;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      req = 1'b0;
      if (cyc == 8) begin
        checkOutput("midrst_busyA_c8", 32'(busyA), 32'd1);
        reset = 1'b1;
      end
    end
    tick();
    reset = 1'b0;
    checkOutput("midrst_busyA", 32'(busyA), 32'd0);
    checkOutput("midrst_doneA", 32'(doneA), 32'd0);
    checkOutput("midrst_lrA", 32'(lrA), 32'd0);
    checkOutput("midrst_pixA", 32'(pixA), 32'd0);
    checkOutput("midrst_readyA", 32'(readyA), 32'd1);
    checkOutput("midrst_readyB", 32'(readyB), 32'd1);
    checkOutput("midrst_addrA", 32'(romAddrA), 32'd0);
    for (int cyc = 10; cyc <= 24; cyc++) begin
      pixX = 6'(cyc);
      tick();
      checkOutput($sformatf("midrst_doneA_c%0d", cyc), 32'(doneA), 32'd0);
      checkOutput($sformatf("midrst_doneB_c%0d", cyc), 32'(doneB), 32'd0);
      checkOutput($sformatf("midrst_lrA_c%0d", cyc), 32'(lrA), 32'd0);
      checkOutput($sformatf("midrst_pixA_c%0d", cyc), 32'(pixA), 32'd0);
      checkOutput($sformatf("midrst_pixB_c%0d", cyc), 32'(pixB), 32'd0);
    end

    applyStimulus(3'd1, 6'd10, 0);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    checkPixels(3'd1, 6'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_row_fetch.md
SPRITE_ROW_FETCH -- requirements
Module: sprite_row_fetch

Interface
REQ-001 Parameter ROM_LAT, default 3, SHALL be the read latency in clk cycles from rom_word_addr_o/rom_sprite_sel_o to valid rom_data_i.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_i  input  1  fetch request for one sprite row.
REQ-005 sprite_sel_i  input  3  sprite index, captured on accept.
REQ-006 row_i  input  6  sprite row 0..63, captured on accept.
REQ-007 ready_o  output  1  request accepted this cycle if req_i=1.
REQ-008 busy_o  output  1  fetch in progress.
REQ-009 done_o  output  1  one-cycle pulse at fetch completion.
REQ-010 line_ready_o  output  1  back buffer holds a complete, unswapped row.
REQ-011 swap_i  input  1  line-boundary strobe requesting buffer swap.
REQ-012 rom_sprite_sel_o  output  3  sprite select to sprite ROM.
REQ-013 rom_word_addr_o  output  10  word address to sprite ROM.
REQ-014 rom_data_i  input  16  sprite ROM read data.
REQ-015 pix_x_i  input  6  display pixel column 0..63.
REQ-016 pix_o  output  4  4-bpp pixel from front buffer.

Function
REQ-017 Row layout: 64 pixels at 4 bpp = 16 words; word address = {row[5:0], k[3:0]}, k = 0..15.
REQ-018 Pixel packing: word k bits [15:12] = pixel 4k, [11:8] = 4k+1, [7:4] = 4k+2, [3:0] = 4k+3.
REQ-019 Two 64x4 line buffers (front, back); fetch writes back only, pix_o reads front only.
REQ-020 ready_o = 1 iff FSM in IDLE and line_ready_o = 0; req_i with ready_o = 0 is ignored, not queued.
REQ-021 FSM states IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-022 IDLE -> ISSUE on req_i & ready_o (accept cycle = cycle 0); sprite_sel_i and row_i latched.
REQ-023 ISSUE: registered ROM outputs present word k at cycle 1+k, k = 0..15; then -> DRAIN.
REQ-024 Data tracking: ROM_LAT-deep valid/index shift pipeline; rom_data_i written to back buffer word k at cycle 1+k+ROM_LAT.
REQ-025 DRAIN persists until last write (cycle 16+ROM_LAT), then -> DONE.
REQ-026 DONE, cycle 17+ROM_LAT (20 at default): done_o = 1, line_ready_o rises this cycle; next state IDLE.
REQ-027 busy_o = 1 in ISSUE and DRAIN (cycles 1..16+ROM_LAT), 0 in DONE and IDLE.
REQ-028 rom_word_addr_o and rom_sprite_sel_o hold their last value when not issuing.
REQ-029 Swap: on a cycle with swap_i = 1 and line_ready_o = 1, next edge exchanges front/back, clears line_ready_o, sets front_valid.
REQ-030 swap_i with line_ready_o = 0 is ignored; front stays displayed (repeat previous row).
REQ-031 swap_i coincident with done_o SHALL swap (line_ready_o already 1 that cycle).
REQ-032 pix_o registered: 1-cycle latency from pix_x_i; pix_o = 0 while front_valid = 0.
REQ-033 sprite_sel_i = 7 is passed through unchanged; stored pixels are whatever ROM returns.

Reset
REQ-034 reset SHALL force FSM IDLE, busy_o = 0, done_o = 0, line_ready_o = 0, front_valid = 0, pix_o = 0, ROM outputs = 0, valid pipeline cleared.
REQ-035 Reset mid-fetch SHALL abandon the fetch; no done_o, no line_ready_o; ready_o = 1 the cycle after reset deasserts.
REQ-036 Buffer contents need not be reset; front_valid gating makes them unobservable.

Verification
REQ-037 Basic fetch: req sprite 2 row 5, ROM model lat 3 -> addresses 0x050..0x05F cycles 1..16, rom_sprite_sel_o = 2, done_o at cycle 20 only, busy_o high cycles 1..19.
REQ-038 Packing: ROM word 0x050 = 0x1234, swap -> pix_x 0..3 return 1,2,3,4 one cycle after each pix_x_i.
REQ-039 Backpressure: second req while busy and while line_ready_o = 1 -> ignored, no ROM traffic; accepted only after swap.
REQ-040 Swap edge cases: swap_i before any fetch -> pix_o = 0; swap_i same cycle as done_o -> new row visible, line_ready_o low next cycle.
REQ-041 Reset at cycle 8 of fetch -> no done_o, line_ready_o = 0, pix_o = 0; fresh req then completes normally in 20 cycles.
REQ-042 ROM_LAT = 1 parameter sweep -> done_o at cycle 18, all 16 words land at correct indices.
